// File: rtl/traffic_timer.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_timer
//  Description : Prescaled interval timer with short/long elapsed flags and
//                an IDLE/RUN/DONE controller. Optional macro TIMER_LOAD_EN
//                adds runtime-loadable thresholds.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_timer #(
  parameter int PRESCALE    = 4,
  parameter int CNT_W       = 8,
  parameter int SHORT_TICKS = 3,
  parameter int LONG_TICKS  = 10
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             ST,
`ifdef TIMER_LOAD_EN
  input  logic             load,
  input  logic [CNT_W-1:0] load_short,
  input  logic [CNT_W-1:0] load_long,
`endif
  output logic             TS,
  output logic             TL
);

  localparam int              PS_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST     = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ELAPSED_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PS_W-1:0]  prescale, prescale_nxt;
  logic [CNT_W-1:0] elapsed, elapsed_nxt;
  logic [CNT_W-1:0] short_thr, long_thr;
  logic [CNT_W-1:0] short_thr_nxt, long_thr_nxt;

`ifdef TIMER_LOAD_EN
  assign short_thr_nxt = load ? load_short : short_thr;
  assign long_thr_nxt  = load ? load_long  : long_thr;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      short_thr <= CNT_W'(SHORT_TICKS);
      long_thr  <= CNT_W'(LONG_TICKS);
    end else begin
      short_thr <= short_thr_nxt;
      long_thr  <= long_thr_nxt;
    end
  end
`else
  assign short_thr     = CNT_W'(SHORT_TICKS);
  assign long_thr      = CNT_W'(LONG_TICKS);
  assign short_thr_nxt = short_thr;
  assign long_thr_nxt  = long_thr;
`endif

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prescale <= '0;
      elapsed  <= '0;
    end else begin
      state    <= state_nxt;
      prescale <= prescale_nxt;
      elapsed  <= elapsed_nxt;
    end
  end

  // DONE decisions use post-edge counter and threshold values so the state
  // agrees with the flags from the very cycle they change.
  always_comb begin
    state_nxt    = state;
    prescale_nxt = prescale;
    elapsed_nxt  = elapsed;
    if (ST) begin
      state_nxt    = RUN;
      prescale_nxt = '0;
      elapsed_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          prescale_nxt = '0;
          elapsed_nxt  = '0;
        end
        RUN: begin
          if (prescale == PS_LAST) begin
            prescale_nxt = '0;
            if (elapsed != ELAPSED_MAX)
              elapsed_nxt = elapsed + CNT_W'(1);
          end else begin
            prescale_nxt = prescale + PS_W'(1);
          end
          if ((elapsed_nxt >= short_thr_nxt) && (elapsed_nxt >= long_thr_nxt))
            state_nxt = DONE;
        end
        DONE: begin
          if (!((elapsed >= short_thr_nxt) && (elapsed >= long_thr_nxt)))
            state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign TS = (state != IDLE) && (elapsed >= short_thr);
  assign TL = (state != IDLE) && (elapsed >= long_thr);

endmodule
`default_nettype wire

// File: tb/tb_traffic_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_timer
//  Description : Directed self-checking bench for traffic_timer (defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_timer;

  logic       Clk = 1'b0;
  logic       reset;
  logic       ST;
  logic       TS;
  logic       TL;
`ifdef TIMER_LOAD_EN
  logic       load;
  logic [7:0] load_short;
  logic [7:0] load_long;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  traffic_timer dut (
    .Clk        (Clk),
    .reset      (reset),
    .ST         (ST),
`ifdef TIMER_LOAD_EN
    .load       (load),
    .load_short (load_short),
    .load_long  (load_long),
`endif
    .TS         (TS),
    .TL         (TL)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Pulse ST for one edge (edge 0); returns 1 time unit after edge 0.
  task automatic start();
    ST = 1'b1;
    @(posedge Clk);
    #1;
    ST = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ST    = 1'b0;
`ifdef TIMER_LOAD_EN
    load       = 1'b0;
    load_short = 8'd0;
    load_long  = 8'd0;
`endif
    #22;
    chk("reset_ts", TS, 0);
    chk("reset_tl", TL, 0);
    chk("reset_elapsed", dut.elapsed, 0);
    reset = 1'b0;

    // Basic run: TS after edge 12, TL and DONE after edge 40
    start();
    chk("run_edge0_ts", TS, 0);
    tick(11);
    chk("run_e11_ts", TS, 0);
    tick(1);
    chk("run_e12_ts", TS, 1);
    chk("run_e12_tl", TL, 0);
    chk("run_e12_elapsed", dut.elapsed, 3);
    tick(27);
    chk("run_e39_tl", TL, 0);
    tick(1);
    chk("run_e40_tl", TL, 1);
    chk("run_e40_ts", TS, 1);
    chk("run_e40_elapsed", dut.elapsed, 10);
    tick(100);
    chk("done_hold_ts", TS, 1);
    chk("done_hold_tl", TL, 1);
    chk("done_hold_elapsed", dut.elapsed, 10);
    chk("done_hold_prescale", dut.prescale, 0);

    // Retrigger at edge 20
    start();
    tick(19);
    chk("retrig_e19_ts", TS, 1);
    ST = 1'b1;
    #1;
    chk("retrig_st_no_comb_ts", TS, 1);
    tick(1);
    ST = 1'b0;
    chk("retrig_e20_ts", TS, 0);
    chk("retrig_e20_elapsed", dut.elapsed, 0);
    tick(11);
    chk("retrig_e31_ts", TS, 0);
    tick(1);
    chk("retrig_e32_ts", TS, 1);
    tick(27);
    chk("retrig_e59_tl", TL, 0);
    tick(1);
    chk("retrig_e60_tl", TL, 1);

    // Asynchronous reset between edges 25 and 26
    start();
    tick(25);
    chk("rst_mid_before_ts", TS, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_async_ts", TS, 0);
    chk("rst_mid_async_elapsed", dut.elapsed, 0);
    @(negedge Clk);
    reset = 1'b0;
    tick(60);
    chk("rst_mid_idle_ts", TS, 0);
    chk("rst_mid_idle_tl", TL, 0);
    chk("rst_mid_idle_elapsed", dut.elapsed, 0);

    // ST held high for 50 edges
    ST = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("st_hold_ts", TS, 0);
      chk("st_hold_tl", TL, 0);
    end
    ST = 1'b0;
    tick(11);
    chk("st_hold_e11_ts", TS, 0);
    tick(1);
    chk("st_hold_e12_ts", TS, 1);

    // Reset while in DONE
    tick(28);
    chk("rst_done_pre_tl", TL, 1);
    reset = 1'b1;
    #1;
    chk("rst_done_ts", TS, 0);
    chk("rst_done_tl", TL, 0);
    @(negedge Clk);
    reset = 1'b0;
    tick(5);
    chk("rst_done_idle_ts", TS, 0);

`ifdef TIMER_LOAD_EN
    // Load and ST on the same edge
    load_short = 8'd1;
    load_long  = 8'd2;
    load       = 1'b1;
    start();
    load = 1'b0;
    tick(3);
    chk("load_e3_ts", TS, 0);
    tick(1);
    chk("load_e4_ts", TS, 1);
    tick(3);
    chk("load_e7_tl", TL, 0);
    tick(1);
    chk("load_e8_tl", TL, 1);
    // Raising long threshold in DONE resumes counting
    load_long = 8'd5;
    load      = 1'b1;
    tick(1);
    load = 1'b0;
    chk("load_done_e9_tl", TL, 0);
    chk("load_done_e9_ts", TS, 1);
    tick(12);
    chk("load_done_e21_tl", TL, 1);
    // Reset restores default thresholds
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    start();
    tick(11);
    chk("load_rst_e11_ts", TS, 0);
    tick(1);
    chk("load_rst_e12_ts", TS, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
